// File: rtl/delta_decoder.sv
// Inverse of the sample-strobed accumulator. It takes the first difference of
// successive Acc captures and averages 2^LOG2N of them onto a valid/ready port.
module delta_decoder #(
  parameter int WIDTH = 26,
  parameter int LOG2N = 2
) (
  input  logic             clk,
  input  logic             GlobalReset,
  input  logic             sample,
  input  logic [WIDTH-1:0] Acc,
  input  logic             Ready,
  input  logic             ClrOvr,
  output logic [WIDTH-1:0] Delta,
  output logic             Valid,
  output logic             Overrun
);

  localparam int CW = (LOG2N > 0) ? LOG2N : 1;
  localparam int SW = WIDTH + LOG2N;
  localparam logic [CW-1:0] CNT_MAX = CW'((1 << LOG2N) - 1);

  typedef enum logic {EMPTY, RUN} state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic             stb;
  logic [WIDTH-1:0] last_q, last_d;
  logic [SW-1:0]    sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] delta_q, delta_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic [WIDTH-1:0] diff;
  logic [SW-1:0]    sum_next;

  // s1/s2 resynchronise the asynchronous strobe; s3 turns its rising edge into one pulse.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sample;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign stb = s2_q & ~s3_q;

  // Modulo subtraction makes an accumulator wrap still read as a positive increment.
  assign diff     = Acc - last_q;
  assign sum_next = sum_q + SW'(diff);

  // NOTE: every variable gets its hold value first, so no path through this block infers a latch.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    delta_d = delta_q;
    valid_d = valid_q & ~Ready;
    ovr_d   = ovr_q & ~ClrOvr;

    if (stb) begin
      last_d = Acc;
      unique case (state_q)
        EMPTY: begin
          sum_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
        RUN: begin
          if (cnt_q == CNT_MAX) begin
            delta_d = WIDTH'(sum_next >> LOG2N);
            valid_d = 1'b1;
            sum_d   = '0;
            cnt_d   = '0;
            // Set beats ClrOvr when the unconsumed result is overwritten.
            if (valid_q && !Ready) ovr_d = 1'b1;
          end else begin
            sum_d = sum_next;
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      state_q <= EMPTY;
      last_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      delta_q <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      delta_q <= delta_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign Delta   = delta_q;
  assign Valid   = valid_q;
  assign Overrun = ovr_q;

endmodule
